toast_id_issue_stage: RTL and testbench
=======================================

Name: toast_id_issue_stage

Overview:
Parametrised ID/EX pipeline register for the Toast core. It replaces fixed always-advance decode registers with a valid/ready handshake and an opaque decoded-control bundle of configurable width. It bypasses operands from NUM_WB writeback ports at capture time, and keeps snooping those ports while an instruction is held, so late writebacks are never missed. It also detects load-use hazards and back-pressures fetch/decode.

Parameters:
XLEN, 32, data/PC width
ADDR_W, 5, register address width
CTRL_W, 24, width of opaque decoded control bundle
NUM_WB, 2, number of writeback/bypass ports; lower index = higher priority (younger result)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
flush_i  in  1  kill instruction held in stage (branch/jump/exception)
in_valid_i  in  1  decoded instruction valid
in_ready_o  out  1  stage accepts instruction this cycle
in_pc_i  in  XLEN  instruction PC
in_ctrl_i  in  CTRL_W  decoded control bundle
in_rd_addr_i / in_rs1_addr_i / in_rs2_addr_i  in  ADDR_W each  register addresses
in_rs1_used_i / in_rs2_used_i  in  1 each  instruction reads rs1/rs2
in_is_load_i  in  1  instruction is a load
in_rs1_data_i / in_rs2_data_i  in  XLEN each  regfile read data
wb_wr_en_i  in  NUM_WB  writeback enables
wb_rd_addr_i  in  NUM_WB*ADDR_W  writeback addresses, port k at [k*ADDR_W +: ADDR_W]
wb_data_i  in  NUM_WB*XLEN  writeback data, port k at [k*XLEN +: XLEN]
out_valid_o  out  1  stage holds valid instruction
out_ready_i  in  1  EX accepts instruction
out_pc_o  out  XLEN  registered PC
out_ctrl_o  out  CTRL_W  registered control; all-zero (NOP) when out_valid_o=0
out_rd_addr_o / out_rs1_addr_o / out_rs2_addr_o  out  ADDR_W each  registered addresses
out_is_load_o  out  1  registered load flag, 0 when invalid
out_rs1_data_o / out_rs2_data_o  out  XLEN each  registered, bypass-corrected operands
hazard_o  out  1  load-use hazard this cycle (combinational)

Behaviour:
- Reset (async, reset_i=1): every output register 0; out_valid_o=0. Outputs are registered except in_ready_o and hazard_o.
- Hazard: hazard_o = in_valid_i & out_valid_o & out_is_load_o & (out_rd_addr_o!=0) & ((in_rs1_used_i & in_rs1_addr_i==out_rd_addr_o) | (in_rs2_used_i & in_rs2_addr_i==out_rd_addr_o)).
- in_ready_o = (~out_valid_o | out_ready_i) & ~hazard_o & ~flush_i.
- fire_in = in_valid_i & in_ready_o. On fire_in, next cycle: out_valid_o=1 and all payload is captured (1-cycle latency).
- Capture bypass, per operand X:
  - addr 0 -> 0.
  - Otherwise the lowest-index k with wb_wr_en_i[k] & wb addr==in_rsX_addr_i gives wb_data_i[k].
  - Otherwise in_rsX_data_i.
- Hold snoop: if out_valid_o & ~out_ready_i & ~flush_i, each cycle every stored operand with nonzero address is overwritten by the highest-priority matching WB port. Addresses, PC and ctrl are unchanged.
- Drain: out_ready_i=1 with no fire_in -> out_valid_o=0, out_ctrl_o=0, out_is_load_o=0 (bubble). Simultaneous drain and fire_in -> new instruction replaces the old one, with no bubble.
- Hazard with out_ready_i=1: the load leaves and a bubble is inserted. Next cycle the hazard clears (out_is_load_o=0) and the dependent instruction is accepted.
- Flush: highest priority after reset. Next cycle out_valid_o=0, ctrl/is_load cleared, no capture (in_ready_o=0 during flush). Data/address registers may retain stale values.
- Payload registers do not update when invalid and not firing; consumers ignore data when out_valid_o=0.
- Reset asserted mid-hold discards the held instruction immediately.

Test Plan:
- Reset, then in_valid_i=1, pc=0x100, rs1=3 (regfile 0x11) with out_ready_i=1 -> next cycle out_valid_o=1, out_pc_o=0x100, out_rs1_data_o=0x11.
- Capture with wb0 (x3,0xAA) and wb1 (x3,0xBB) both enabled, rs1=3 -> out_rs1_data_o=0xAA; rs2=0 with wb writing x0 -> out_rs2_data_o=0.
- Hold with out_ready_i=0 for 3 cycles, wb1 writes x5=0xCAFE in cycle 2, stored rs2=5 -> out_rs2_data_o=0xCAFE from cycle 3; pc/ctrl unchanged.
- Load to rd=7 held with out_ready_i=1; next instruction uses rs2=7 -> hazard_o=1, in_ready_o=0, one bubble (out_valid_o=0, out_ctrl_o=0); dependent instruction accepted the following cycle.
- Same load-use with in_rs2_used_i=0, or rd=0 -> hazard_o=0, no bubble.
- flush_i=1 while in_valid_i=1 and out_valid_o=1 -> next cycle out_valid_o=0, out_ctrl_o=0, input not captured; reset_i pulse mid-hold -> out_valid_o=0 immediately.

Source files
------------

// File: rtl/toast_id_issue_stage.sv
// Toast core ID/EX issue stage: valid/ready pipeline register with
// writeback bypass at capture, writeback snooping while held, and
// load-use hazard detection that back-pressures decode.

// Priority writeback match for one register address.
// Port 0 carries the youngest result, so it wins over higher-numbered ports.
module toast_id_issue_bypass #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WB = 2
) (
    input  logic [ADDR_W-1:0]        rs_addr,
    input  logic [NUM_WB-1:0]        wb_wr_en,
    input  logic [NUM_WB*ADDR_W-1:0] wb_rd_addr,
    input  logic [NUM_WB*XLEN-1:0]   wb_data,
    output logic                     hit,
    output logic [XLEN-1:0]          hit_data
);

    // Scan from lowest priority upward so the lowest matching index is left last.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_wr_en[k] && (wb_rd_addr[k*ADDR_W +: ADDR_W] == rs_addr)) begin
                hit      = 1'b1;
                hit_data = wb_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

module toast_id_issue_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 24,
    parameter int NUM_WB = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          in_pc_i,
    input  logic [CTRL_W-1:0]        in_ctrl_i,
    input  logic [ADDR_W-1:0]        in_rd_addr_i,
    input  logic [ADDR_W-1:0]        in_rs1_addr_i,
    input  logic [ADDR_W-1:0]        in_rs2_addr_i,
    input  logic                     in_rs1_used_i,
    input  logic                     in_rs2_used_i,
    input  logic                     in_is_load_i,
    input  logic [XLEN-1:0]          in_rs1_data_i,
    input  logic [XLEN-1:0]          in_rs2_data_i,
    input  logic [NUM_WB-1:0]        wb_wr_en_i,
    input  logic [NUM_WB*ADDR_W-1:0] wb_rd_addr_i,
    input  logic [NUM_WB*XLEN-1:0]   wb_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [CTRL_W-1:0]        out_ctrl_o,
    output logic [ADDR_W-1:0]        out_rd_addr_o,
    output logic [ADDR_W-1:0]        out_rs1_addr_o,
    output logic [ADDR_W-1:0]        out_rs2_addr_o,
    output logic                     out_is_load_o,
    output logic [XLEN-1:0]          out_rs1_data_o,
    output logic [XLEN-1:0]          out_rs2_data_o,
    output logic                     hazard_o
);

    localparam int NUM_OPS = 2;

    // Operands handled as a packed pair: index 0 = rs1, index 1 = rs2.
    logic [NUM_OPS-1:0][ADDR_W-1:0] in_rs_addr;
    logic [NUM_OPS-1:0][XLEN-1:0]   in_rs_data;
    logic [NUM_OPS-1:0]             in_rs_used;
    logic [NUM_OPS-1:0][ADDR_W-1:0] rs_addr_q;
    logic [NUM_OPS-1:0][XLEN-1:0]   rs_data_q;

    logic [NUM_OPS-1:0]             cap_hit;
    logic [NUM_OPS-1:0][XLEN-1:0]   cap_hit_data;
    logic [NUM_OPS-1:0][XLEN-1:0]   cap_data;
    logic [NUM_OPS-1:0]             snoop_hit;
    logic [NUM_OPS-1:0][XLEN-1:0]   snoop_data;
    logic [NUM_OPS-1:0]             dep_on_load;

    logic fire_in;
    logic hold;

    assign in_rs_addr[0] = in_rs1_addr_i;
    assign in_rs_addr[1] = in_rs2_addr_i;
    assign in_rs_data[0] = in_rs1_data_i;
    assign in_rs_data[1] = in_rs2_data_i;
    assign in_rs_used[0] = in_rs1_used_i;
    assign in_rs_used[1] = in_rs2_used_i;

    assign out_rs1_addr_o = rs_addr_q[0];
    assign out_rs2_addr_o = rs_addr_q[1];
    assign out_rs1_data_o = rs_data_q[0];
    assign out_rs2_data_o = rs_data_q[1];

    for (genvar op = 0; op < NUM_OPS; op++) begin : g_op
        // Bypass for the operand arriving from decode.
        toast_id_issue_bypass #(
            .XLEN   (XLEN),
            .ADDR_W (ADDR_W),
            .NUM_WB (NUM_WB)
        ) u_cap (
            .rs_addr    (in_rs_addr[op]),
            .wb_wr_en   (wb_wr_en_i),
            .wb_rd_addr (wb_rd_addr_i),
            .wb_data    (wb_data_i),
            .hit        (cap_hit[op]),
            .hit_data   (cap_hit_data[op])
        );

        // Snoop for the operand already held in the stage.
        toast_id_issue_bypass #(
            .XLEN   (XLEN),
            .ADDR_W (ADDR_W),
            .NUM_WB (NUM_WB)
        ) u_snoop (
            .rs_addr    (rs_addr_q[op]),
            .wb_wr_en   (wb_wr_en_i),
            .wb_rd_addr (wb_rd_addr_i),
            .wb_data    (wb_data_i),
            .hit        (snoop_hit[op]),
            .hit_data   (snoop_data[op])
        );

        // x0 is hardwired to zero regardless of what writeback claims.
        assign cap_data[op] = (in_rs_addr[op] == '0) ? '0 :
                              cap_hit[op]            ? cap_hit_data[op] :
                                                       in_rs_data[op];

        assign dep_on_load[op] = in_rs_used[op] && (in_rs_addr[op] == out_rd_addr_o);
    end

    assign hazard_o   = in_valid_i && out_valid_o && out_is_load_o &&
                        (out_rd_addr_o != '0) && (|dep_on_load);
    assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard_o && !flush_i;
    assign fire_in    = in_valid_i && in_ready_o;
    assign hold       = out_valid_o && !out_ready_i;

    // Pipeline register: flush kills, fire captures, drain bubbles, hold snoops.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_o   <= 1'b0;
            out_pc_o      <= '0;
            out_ctrl_o    <= '0;
            out_rd_addr_o <= '0;
            out_is_load_o <= 1'b0;
            rs_addr_q     <= '0;
            rs_data_q     <= '0;
        end else if (flush_i) begin
            out_valid_o   <= 1'b0;
            out_ctrl_o    <= '0;
            out_is_load_o <= 1'b0;
        end else if (fire_in) begin
            out_valid_o   <= 1'b1;
            out_pc_o      <= in_pc_i;
            out_ctrl_o    <= in_ctrl_i;
            out_rd_addr_o <= in_rd_addr_i;
            out_is_load_o <= in_is_load_i;
            rs_addr_q     <= in_rs_addr;
            rs_data_q     <= cap_data;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o   <= 1'b0;
            out_ctrl_o    <= '0;
            out_is_load_o <= 1'b0;
        end else if (hold) begin
            for (int op = 0; op < NUM_OPS; op++) begin
                if (snoop_hit[op] && (rs_addr_q[op] != '0)) begin
                    rs_data_q[op] <= snoop_data[op];
                end
            end
        end
    end

endmodule

// File: tb/tb_toast_id_issue_stage.sv
// Self-checking bench for toast_id_issue_stage: directed scenarios from the
// block's intended use plus a randomized run against a behavioural model.
module tb_toast_id_issue_stage;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 24;
    localparam int NUM_WB = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic [XLEN-1:0] in_pc;
    logic [CTRL_W-1:0] in_ctrl;
    logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2;
    logic in_u1, in_u2, in_ld;
    logic [XLEN-1:0] in_d1, in_d2;
    logic [NUM_WB-1:0] wb_en;
    logic [NUM_WB-1:0][ADDR_W-1:0] wb_a;
    logic [NUM_WB-1:0][XLEN-1:0] wb_d;
    logic out_valid, out_ready;
    logic [XLEN-1:0] out_pc;
    logic [CTRL_W-1:0] out_ctrl;
    logic [ADDR_W-1:0] out_rd, out_rs1, out_rs2;
    logic out_ld;
    logic [XLEN-1:0] out_d1, out_d2;
    logic hazard;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    toast_id_issue_stage #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NUM_WB(NUM_WB)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_pc_i        (in_pc),
        .in_ctrl_i      (in_ctrl),
        .in_rd_addr_i   (in_rd),
        .in_rs1_addr_i  (in_rs1),
        .in_rs2_addr_i  (in_rs2),
        .in_rs1_used_i  (in_u1),
        .in_rs2_used_i  (in_u2),
        .in_is_load_i   (in_ld),
        .in_rs1_data_i  (in_d1),
        .in_rs2_data_i  (in_d2),
        .wb_wr_en_i     (wb_en),
        .wb_rd_addr_i   (wb_a),
        .wb_data_i      (wb_d),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_pc_o       (out_pc),
        .out_ctrl_o     (out_ctrl),
        .out_rd_addr_o  (out_rd),
        .out_rs1_addr_o (out_rs1),
        .out_rs2_addr_o (out_rs2),
        .out_is_load_o  (out_ld),
        .out_rs1_data_o (out_d1),
        .out_rs2_data_o (out_d2),
        .hazard_o       (hazard)
    );

    task automatic idle();
        flush = 0; in_valid = 0; in_pc = '0; in_ctrl = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_u1 = 0; in_u2 = 0; in_ld = 0;
        in_d1 = '0; in_d2 = '0; wb_en = '0; wb_a = '0; wb_d = '0;
        out_ready = 1;
    endtask

    task automatic instr(input logic [XLEN-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                         input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                         input logic [ADDR_W-1:0] rs2, input logic u1, input logic u2,
                         input logic ld, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        in_valid = 1; in_pc = pc; in_ctrl = ctrl; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_u1 = u1; in_u2 = u2; in_ld = ld; in_d1 = d1; in_d2 = d2;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        #3;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_pc !== '0) begin n_err++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        n_vec++; if (out_ctrl !== '0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", out_ctrl); end
        n_vec++; if (out_d1 !== '0 || out_d2 !== '0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0", out_d1, out_d2); end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_capture();
        instr(32'h100, 24'h000A01, 5'd1, 5'd3, 5'd4, 1, 1, 0, 32'h11, 32'h22);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL cap_ready: got %b want 1", in_ready); end
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL cap_valid: got %b want 1", out_valid); end
        n_vec++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL cap_pc: got %h want 100", out_pc); end
        n_vec++; if (out_d1 !== 32'h11) begin n_err++; $display("FAIL cap_rs1: got %h want 11", out_d1); end
        // Both WB ports write x3: port 0 is younger and must win.
        instr(32'h104, 24'h000A02, 5'd2, 5'd3, 5'd4, 1, 1, 0, 32'h11, 32'h22);
        wb_en = 2'b11; wb_a[0] = 5'd3; wb_d[0] = 32'hAA; wb_a[1] = 5'd3; wb_d[1] = 32'hBB;
        step();
        n_vec++; if (out_d1 !== 32'hAA) begin n_err++; $display("FAIL cap_wb_prio: got %h want aa", out_d1); end
        n_vec++; if (out_d2 !== 32'h22) begin n_err++; $display("FAIL cap_rf_rs2: got %h want 22", out_d2); end
        // x0 reads zero even when a WB port claims to write it; port 1 alone still bypasses.
        instr(32'h108, 24'h000A03, 5'd2, 5'd6, 5'd0, 1, 1, 0, 32'h33, 32'h77);
        wb_en = 2'b11; wb_a[0] = 5'd0; wb_d[0] = 32'h55; wb_a[1] = 5'd6; wb_d[1] = 32'h66;
        step();
        n_vec++; if (out_d2 !== 32'h0) begin n_err++; $display("FAIL cap_x0: got %h want 0", out_d2); end
        n_vec++; if (out_d1 !== 32'h66) begin n_err++; $display("FAIL cap_wb1: got %h want 66", out_d1); end
        idle();
        step();
        n_vec++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_err++; $display("FAIL drain_bubble: got v=%b ctrl=%h want 0/0", out_valid, out_ctrl); end
    endtask

    task automatic test_hold_snoop();
        instr(32'h200, 24'hABCDE, 5'd8, 5'd0, 5'd5, 0, 1, 0, 32'h0, 32'h1234);
        step();
        in_valid = 0; out_ready = 0;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready: got %b want 0", in_ready); end
        step();
        n_vec++; if (out_d2 !== 32'h1234) begin n_err++; $display("FAIL hold_c1: got %h want 1234", out_d2); end
        wb_en = 2'b10; wb_a[1] = 5'd5; wb_d[1] = 32'hCAFE;
        step();
        wb_en = '0;
        n_vec++; if (out_d2 !== 32'hCAFE) begin n_err++; $display("FAIL hold_snoop: got %h want cafe", out_d2); end
        step();
        n_vec++; if (out_d2 !== 32'hCAFE) begin n_err++; $display("FAIL hold_keep: got %h want cafe", out_d2); end
        n_vec++; if (out_pc !== 32'h200 || out_ctrl !== 24'hABCDE || out_valid !== 1'b1)
            begin n_err++; $display("FAIL hold_payload: got pc=%h ctrl=%h v=%b want 200/abcde/1", out_pc, out_ctrl, out_valid); end
        out_ready = 1;
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        instr(32'h300, 24'h000111, 5'd7, 5'd1, 5'd2, 1, 1, 1, 32'h1, 32'h2);
        step();
        n_vec++; if (out_ld !== 1'b1) begin n_err++; $display("FAIL lu_load: got %b want 1", out_ld); end
        instr(32'h304, 24'h000222, 5'd9, 5'd2, 5'd7, 1, 1, 0, 32'h3, 32'h4);
        #1;
        n_vec++; if (hazard !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL lu_hazard: got hz=%b rdy=%b want 1/0", hazard, in_ready); end
        step();
        n_vec++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_err++; $display("FAIL lu_bubble: got v=%b ctrl=%h want 0/0", out_valid, out_ctrl); end
        n_vec++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL lu_clear: got hz=%b rdy=%b want 0/1", hazard, in_ready); end
        step();
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h304) begin n_err++; $display("FAIL lu_accept: got v=%b pc=%h want 1/304", out_valid, out_pc); end
        idle();
        step();
    endtask

    task automatic test_no_hazard();
        instr(32'h400, 24'h000333, 5'd7, 5'd1, 5'd2, 1, 1, 1, 32'h1, 32'h2);
        step();
        instr(32'h404, 24'h000444, 5'd9, 5'd2, 5'd7, 1, 0, 0, 32'h3, 32'h4);
        #1;
        n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL nh_unused: got %b want 0", hazard); end
        step();
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h404) begin n_err++; $display("FAIL nh_nobubble: got v=%b pc=%h want 1/404", out_valid, out_pc); end
        instr(32'h408, 24'h000555, 5'd0, 5'd1, 5'd2, 1, 1, 1, 32'h1, 32'h2);
        step();
        instr(32'h40C, 24'h000666, 5'd9, 5'd0, 5'd0, 1, 1, 0, 32'h3, 32'h4);
        #1;
        n_vec++; if (hazard !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL nh_rd0: got hz=%b rdy=%b want 0/1", hazard, in_ready); end
        step();
        n_vec++; if (out_pc !== 32'h40C) begin n_err++; $display("FAIL nh_rd0_pc: got %h want 40c", out_pc); end
        idle();
        step();
    endtask

    task automatic test_flush();
        instr(32'h500, 24'h000777, 5'd1, 5'd1, 5'd2, 1, 1, 0, 32'h1, 32'h2);
        step();
        instr(32'h504, 24'h000888, 5'd2, 5'd1, 5'd2, 1, 1, 1, 32'h1, 32'h2);
        flush = 1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", in_ready); end
        step();
        idle();
        n_vec++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_ld !== 1'b0)
            begin n_err++; $display("FAIL fl_kill: got v=%b ctrl=%h ld=%b want 0/0/0", out_valid, out_ctrl, out_ld); end
        n_vec++; if (out_pc === 32'h504) begin n_err++; $display("FAIL fl_nocapture: got pc=%h want not 504", out_pc); end
        step();
    endtask

    task automatic test_reset_mid_hold();
        instr(32'h600, 24'h000999, 5'd1, 5'd1, 5'd2, 1, 1, 0, 32'h1, 32'h2);
        step();
        idle();
        out_ready = 0;
        step();
        #2;
        rst = 1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_err++; $display("FAIL rst_hold: got v=%b ctrl=%h want 0/0", out_valid, out_ctrl); end
        step();
        rst = 0;
        out_ready = 1;
        step();
    endtask

    // Behavioural reference state for the randomized run.
    logic m_v, m_ld;
    logic [XLEN-1:0] m_pc, m_d1, m_d2;
    logic [CTRL_W-1:0] m_ctrl;
    logic [ADDR_W-1:0] m_rd, m_a1, m_a2;

    // Value an operand should take from the writeback ports: youngest port wins.
    function automatic logic wb_lookup(input logic [ADDR_W-1:0] a, output logic [XLEN-1:0] v);
        v = '0;
        for (int k = 0; k < NUM_WB; k++)
            if (wb_en[k] && wb_a[k] == a) begin v = wb_d[k]; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] read_op(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        if (wb_lookup(a, v)) return v;
        return rf;
    endfunction

    task automatic test_random();
        logic e_hz, e_rdy;
        logic [XLEN-1:0] v;
        m_v = 0; m_ld = 0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_ctrl = '0; m_rd = '0; m_a1 = '0; m_a2 = '0;
        for (int i = 0; i < 400; i++) begin
            flush    = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
            in_pc = $urandom; in_ctrl = CTRL_W'($urandom);
            in_rd = ADDR_W'($urandom_range(0, 7)); in_rs1 = ADDR_W'($urandom_range(0, 7));
            in_rs2 = ADDR_W'($urandom_range(0, 7));
            in_u1 = $urandom_range(0, 1); in_u2 = $urandom_range(0, 1);
            in_ld = ($urandom_range(0, 2) == 0);
            in_d1 = $urandom; in_d2 = $urandom;
            for (int k = 0; k < NUM_WB; k++) begin
                wb_en[k] = $urandom_range(0, 1);
                wb_a[k] = ADDR_W'($urandom_range(0, 7));
                wb_d[k] = $urandom;
            end
            #1;
            e_hz = in_valid && m_v && m_ld && m_rd != 0 &&
                   ((in_u1 && in_rs1 == m_rd) || (in_u2 && in_rs2 == m_rd));
            e_rdy = (!m_v || out_ready) && !e_hz && !flush;
            n_vec++; if (hazard !== e_hz || in_ready !== e_rdy)
                begin n_err++; $display("FAIL rnd_comb[%0d]: got hz=%b rdy=%b want %b/%b", i, hazard, in_ready, e_hz, e_rdy); end
            @(posedge clk);
            if (flush) begin
                m_v = 0; m_ctrl = '0; m_ld = 0;
            end else if (in_valid && e_rdy) begin
                m_v = 1; m_pc = in_pc; m_ctrl = in_ctrl; m_rd = in_rd; m_ld = in_ld;
                m_a1 = in_rs1; m_a2 = in_rs2;
                m_d1 = read_op(in_rs1, in_d1); m_d2 = read_op(in_rs2, in_d2);
            end else if (m_v && out_ready) begin
                m_v = 0; m_ctrl = '0; m_ld = 0;
            end else if (m_v) begin
                if (m_a1 != 0 && wb_lookup(m_a1, v)) m_d1 = v;
                if (m_a2 != 0 && wb_lookup(m_a2, v)) m_d2 = v;
            end
            #1;
            n_vec++; if (out_valid !== m_v || out_ctrl !== m_ctrl || out_ld !== m_ld)
                begin n_err++; $display("FAIL rnd_state[%0d]: got v=%b ctrl=%h ld=%b want %b/%h/%b", i, out_valid, out_ctrl, out_ld, m_v, m_ctrl, m_ld); end
            if (m_v) begin
                n_vec++; if (out_pc !== m_pc || out_rd !== m_rd || out_rs1 !== m_a1 || out_rs2 !== m_a2)
                    begin n_err++; $display("FAIL rnd_payload[%0d]: got pc=%h rd=%0d a=%0d/%0d want %h/%0d/%0d/%0d", i, out_pc, out_rd, out_rs1, out_rs2, m_pc, m_rd, m_a1, m_a2); end
                n_vec++; if (out_d1 !== m_d1 || out_d2 !== m_d2)
                    begin n_err++; $display("FAIL rnd_data[%0d]: got %h/%h want %h/%h", i, out_d1, out_d2, m_d1, m_d2); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_hold_snoop();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
